// File: rtl/button_defs.sv
`default_nettype none
// ============================================================================
// Module   : button_defs (package)
// Purpose  : Shared definitions for the button stages: debounce FSM state
//            encoding, default timing constants and a small helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package button_defs;

  // Debounce FSM states. The two *_WAIT states hold the previous output
  // level while the counter confirms the new input level.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Default timing at 27 MHz: 10 ms debounce, 0.5 s to first repeat,
  // 100 ms between later repeats.
  localparam int DEF_DEBOUNCE_CYCLES = 270000;
  localparam int DEF_CNT_W           = 20;
  localparam int DEF_REPEAT_DELAY    = 13500000;
  localparam int DEF_REPEAT_PERIOD   = 2700000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// Module   : dffr
// Purpose  : Library D flip-flop with synchronous active-high reset to 0.
// Ports    : clk   - clock
//            reset - synchronous reset, active high
//            d     - data in
//            q     - registered data out
// Revision : 1.0  initial release
// ============================================================================
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer for a single asynchronous level.
// Ports    : clk   - destination clock
//            reset - synchronous reset, clears both stages
//            d     - asynchronous input
//            q     - synchronized output (second stage)
// Revision : 1.0  initial release
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  dffr #(.W(1)) u_stage1 (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (meta)
  );

  dffr #(.W(1)) u_stage2 (
    .clk   (clk),
    .reset (reset),
    .d     (meta),
    .q     (q)
  );

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Debounces a raw push-button level and optionally generates
//            auto-repeat strobes while the button is held.
// Ports    : clk          - system clock, all state on rising edge
//            reset        - synchronous reset, active high
//            in           - raw asynchronous button level (active high)
//            out          - debounced level, registered
//            repeat_pulse - one-cycle auto-repeat strobe while held
// Config   : define DEBOUNCE_REPEAT_EN to build the auto-repeat logic;
//            otherwise repeat_pulse is tied to 0.
// Revision : 1.0  initial release
// ============================================================================
module button_debounce
  import button_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Parameter sanity: the counter must reach DEBOUNCE_CYCLES-1 without
  // wrapping, so the terminal count has to fit in CNT_W bits.
  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES >= (1 << CNT_W))) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE_CYCLES=%0d out of range for CNT_W=%0d",
           DEBOUNCE_CYCLES, CNT_W);
  end
  if ((REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_repeat
    $error("button_debounce: REPEAT_DELAY/REPEAT_PERIOD must be >= 1");
  end

  logic             in_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in),
    .q     (in_s)
  );

  // out is written together with the state so it is a registered decode
  // that changes on the same edge as the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!in_s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            out   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!in_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (in_s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            out   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          out   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_REPEAT_EN
  localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;   // first pulse already issued for this hold
  logic             rpt_pulse;

  // Counts every edge on which the registered state is HELD. Any cycle in
  // IDLE or PRESS_WAIT clears the count, so a fresh press always starts
  // from zero on entry to HELD; RELEASE_WAIT leaves it frozen so a release
  // bounce does not shift the repeat phase beyond the frozen cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
      rpt_pulse <= 1'b0;
    end else begin
      rpt_pulse <= 1'b0;
      case (state)
        HELD: begin
          if (rpt_cnt == (rpt_armed ? PERIOD_LAST : DELAY_LAST)) begin
            rpt_pulse <= 1'b1;
            rpt_cnt   <= '0;
            rpt_armed <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        RELEASE_WAIT: begin
        end
        default: begin
          rpt_cnt   <= '0;
          rpt_armed <= 1'b0;
        end
      endcase
    end
  end

  assign repeat_pulse = rpt_pulse;
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule
`default_nettype wire
